// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state type and bit-timing helper
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

  // Clocks per line bit, truncated; uart_rx uses the same rounding so a loopback stays aligned.
  function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
    return clk_hz / bit_rate;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start bit, LSB-first payload, stop bit(s), no parity
module uart_tx
  import uart_pkg::*;
#(
  parameter int BIT_RATE     = 115200,
  parameter int CLK_HZ       = 50000000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    uart_txd,
  output logic                    uart_tx_busy,
  input  logic                    uart_tx_en,
  input  logic [PAYLOAD_BITS-1:0] uart_tx_data
);

  localparam int CPB = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int CW  = $clog2(CPB + 1);
  localparam int IW  = $clog2(PAYLOAD_BITS);

  uart_tx_state_t          state;
  logic [CW-1:0]           cyc_cnt;
  logic [IW-1:0]           bit_idx;
  logic [PAYLOAD_BITS-1:0] shift_reg;
  logic                    bit_end;

  assign bit_end = (cyc_cnt == CW'(CPB - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      uart_txd     <= 1'b1;
      uart_tx_busy <= 1'b0;
      cyc_cnt      <= '0;
      bit_idx      <= '0;
      shift_reg    <= '0;
    end else begin
      case (state)
        IDLE: begin
          uart_txd     <= 1'b1;
          uart_tx_busy <= 1'b0;
          if (uart_tx_en) begin
            shift_reg    <= uart_tx_data;
            state        <= START;
            uart_txd     <= 1'b0;
            uart_tx_busy <= 1'b1;
            cyc_cnt      <= '0;
            bit_idx      <= '0;
          end
        end
        START: begin
          if (bit_end) begin
            cyc_cnt   <= '0;
            state     <= DATA;
            uart_txd  <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cyc_cnt <= '0;
            if (bit_idx == IW'(PAYLOAD_BITS - 1)) begin
              // Stop level is driven here so the line never dips between data and stop.
              state    <= STOP;
              uart_txd <= 1'b1;
              bit_idx  <= '0;
            end else begin
              bit_idx   <= bit_idx + IW'(1);
              uart_txd  <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
            end
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end
        STOP: begin
          uart_txd <= 1'b1;
          if (bit_end) begin
            cyc_cnt <= '0;
            if (bit_idx == IW'(STOP_BITS - 1)) begin
              state        <= IDLE;
              uart_tx_busy <= 1'b0;
              bit_idx      <= '0;
            end else begin
              bit_idx <= bit_idx + IW'(1);
            end
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end
        default: begin
          state        <= IDLE;
          uart_txd     <= 1'b1;
          uart_tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
